// File: rtl/pll_lock_supervisor.sv
// Lock supervisor for one PLL/DCM: drives the PLL reset pulse, filters the lock
// indication, retries on timeout with a sticky fault, and counts lock-loss events.
module pll_lock_supervisor #(
  parameter int unsigned TIMEOUT_CYCLES     = 50000,
  parameter int unsigned RESET_PULSE_CYCLES = 10,
  parameter int unsigned LOCK_FILTER_CYCLES = 256,
  parameter int unsigned MAX_RETRIES        = 7,
  parameter int unsigned CNT_WIDTH          = 17
) (
  input  logic        input_clk,
  input  logic        reset,
  input  logic        input_clk_stable,
  input  logic        pll_locked,
  input  logic        force_relock,
  input  logic        clear_fault,
  output logic        pll_reset,
  output logic        clocks_ready,
  output logic        supervisor_fault,
  output logic [7:0]  retry_count,
  output logic [15:0] lock_loss_count,
  output logic [2:0]  sup_state
);

  typedef enum logic [2:0] {
    StHold     = 3'd0,
    StPllReset = 3'd1,
    StWaitLock = 3'd2,
    StFilter   = 3'd3,
    StReady    = 3'd4,
    StFault    = 3'd5
  } state_e;

  localparam logic [CNT_WIDTH-1:0] PulseLast   = CNT_WIDTH'(RESET_PULSE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] FilterLast  = CNT_WIDTH'(LOCK_FILTER_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TimeoutLast = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CntZero     = '0;
  localparam logic [CNT_WIDTH-1:0] CntOne      = CNT_WIDTH'(1);

  state_e               state_q, state_d;
  logic [1:0]           sync_q, sync_d;
  logic [CNT_WIDTH-1:0] pulse_cnt_q, pulse_cnt_d;
  logic [CNT_WIDTH-1:0] timer_q, timer_d;
  logic [CNT_WIDTH-1:0] filt_cnt_q, filt_cnt_d;
  logic [7:0]           retry_q, retry_d;
  logic [15:0]          loss_q, loss_d;

  logic       lock_s;
  logic [7:0] retry_inc;
  logic       retries_exhausted;

  // sync_q[1] is the second synchroniser stage; everything below sees only it
  assign sync_d = {sync_q[0], pll_locked};
  assign lock_s = sync_q[1];

  assign retry_inc         = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;
  assign retries_exhausted = (MAX_RETRIES != 0) && (32'(retry_inc) >= MAX_RETRIES);

  always_comb begin
    state_d     = state_q;
    pulse_cnt_d = pulse_cnt_q;
    timer_d     = timer_q;
    filt_cnt_d  = filt_cnt_q;
    retry_d     = retry_q;
    loss_d      = loss_q;

    if (state_q != StFault && !input_clk_stable) begin
      state_d     = StHold;
      pulse_cnt_d = CntZero;
      timer_d     = CntZero;
      filt_cnt_d  = CntZero;
    end else if (state_q == StFault) begin
      if (clear_fault) begin
        state_d     = StPllReset;
        retry_d     = 8'd0;
        pulse_cnt_d = CntZero;
        timer_d     = CntZero;
        filt_cnt_d  = CntZero;
      end
    end else if (force_relock && state_q != StHold) begin
      state_d     = StPllReset;
      pulse_cnt_d = CntZero;
      timer_d     = CntZero;
      filt_cnt_d  = CntZero;
    end else begin
      case (state_q)
        StHold: begin
          state_d     = StPllReset;
          pulse_cnt_d = CntZero;
        end
        StPllReset: begin
          if (pulse_cnt_q == PulseLast) begin
            state_d     = StWaitLock;
            pulse_cnt_d = CntZero;
            timer_d     = CntZero;
            filt_cnt_d  = CntZero;
          end else begin
            pulse_cnt_d = pulse_cnt_q + CntOne;
          end
        end
        StWaitLock, StFilter: begin
          // A completed filter wins over a timeout landing on the same cycle
          if (state_q == StFilter && lock_s && filt_cnt_q == FilterLast) begin
            state_d    = StReady;
            retry_d    = 8'd0;
            filt_cnt_d = CntZero;
            timer_d    = CntZero;
          end else if (timer_q == TimeoutLast) begin
            retry_d     = retry_inc;
            state_d     = retries_exhausted ? StFault : StPllReset;
            pulse_cnt_d = CntZero;
            timer_d     = CntZero;
            filt_cnt_d  = CntZero;
          end else begin
            timer_d = timer_q + CntOne;
            if (state_q == StWaitLock) begin
              if (lock_s) begin
                state_d    = StFilter;
                filt_cnt_d = CntZero;
              end
            end else if (!lock_s) begin
              state_d    = StWaitLock;
              filt_cnt_d = CntZero;
            end else begin
              filt_cnt_d = filt_cnt_q + CntOne;
            end
          end
        end
        StReady: begin
          if (!lock_s) begin
            state_d     = StPllReset;
            pulse_cnt_d = CntZero;
            if (loss_q != 16'hFFFF) begin
              loss_d = loss_q + 16'd1;
            end
          end
        end
        default: begin
          state_d     = StPllReset;
          pulse_cnt_d = CntZero;
          timer_d     = CntZero;
          filt_cnt_d  = CntZero;
        end
      endcase
    end
  end

  always_ff @(posedge input_clk or posedge reset) begin
    if (reset) begin
      state_q     <= StPllReset;
      sync_q      <= 2'b00;
      pulse_cnt_q <= '0;
      timer_q     <= '0;
      filt_cnt_q  <= '0;
      retry_q     <= 8'd0;
      loss_q      <= 16'd0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      pulse_cnt_q <= pulse_cnt_d;
      timer_q     <= timer_d;
      filt_cnt_q  <= filt_cnt_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
    end
  end

  always_comb begin
    pll_reset        = (state_q == StHold) || (state_q == StPllReset) || (state_q == StFault);
    clocks_ready     = (state_q == StReady);
    supervisor_fault = (state_q == StFault);
    retry_count      = retry_q;
    lock_loss_count  = loss_q;
    sup_state        = state_q;
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scenario bench for pll_lock_supervisor: expected outputs are queued per cycle
// and compared as the run reaches that cycle.
module tb_pll_lock_supervisor;

  localparam int FState  = 0;
  localparam int FPllRst = 1;
  localparam int FReady  = 2;
  localparam int FFault  = 3;
  localparam int FRetry  = 4;
  localparam int FLoss   = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        stable;
  logic        locked;
  logic        force_r;
  logic        clear_f;
  logic        pll_reset;
  logic        clocks_ready;
  logic        supervisor_fault;
  logic [7:0]  retry_count;
  logic [15:0] lock_loss_count;
  logic [2:0]  sup_state;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    int    cyc;
    int    field;
    int    val;
    string tag;
  } exp_t;

  exp_t sb[$];

  pll_lock_supervisor #(
    .TIMEOUT_CYCLES    (100),
    .RESET_PULSE_CYCLES(4),
    .LOCK_FILTER_CYCLES(8),
    .MAX_RETRIES       (3),
    .CNT_WIDTH         (17)
  ) dut (
    .input_clk       (clk),
    .reset           (rst),
    .input_clk_stable(stable),
    .pll_locked      (locked),
    .force_relock    (force_r),
    .clear_fault     (clear_f),
    .pll_reset       (pll_reset),
    .clocks_ready    (clocks_ready),
    .supervisor_fault(supervisor_fault),
    .retry_count     (retry_count),
    .lock_loss_count (lock_loss_count),
    .sup_state       (sup_state)
  );

  always #5 clk = ~clk;

  function automatic void want(input int c, input int f, input int v, input string tag);
    exp_t e;
    e.cyc   = c;
    e.field = f;
    e.val   = v;
    e.tag   = tag;
    sb.push_back(e);
  endfunction

  function automatic int obs(input int f);
    case (f)
      FState:  return int'(sup_state);
      FPllRst: return int'(pll_reset);
      FReady:  return int'(clocks_ready);
      FFault:  return int'(supervisor_fault);
      FRetry:  return int'(retry_count);
      FLoss:   return int'(lock_loss_count);
      default: return -1;
    endcase
  endfunction

  // Cycle 0 is the interval right after reset is released on a falling edge;
  // cycle n is observed on the n-th falling edge after that.
  task automatic do_reset(input logic lock0);
    rst     = 1'b1;
    stable  = 1'b1;
    locked  = lock0;
    force_r = 1'b0;
    clear_f = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1; stable = 1'b1; locked = 1'b0; force_r = 1'b0; clear_f = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    tests += 4;
    if (sup_state !== 3'd1) begin
      failed++; $display("FAIL rst_state: got %0d, expected 1", sup_state);
    end
    if (pll_reset !== 1'b1 || clocks_ready !== 1'b0) begin
      failed++; $display("FAIL rst_outs: got rst=%0b rdy=%0b, expected 1/0", pll_reset, clocks_ready);
    end
    if (supervisor_fault !== 1'b0) begin
      failed++; $display("FAIL rst_fault: got %0b, expected 0", supervisor_fault);
    end
    if (retry_count !== 8'd0 || lock_loss_count !== 16'd0) begin
      failed++; $display("FAIL rst_cnts: got %0d/%0d, expected 0/0", retry_count, lock_loss_count);
    end
    rst = 1'b0;
    want(0, FState, 1, "t1_pulse_start");  want(0, FPllRst, 1, "t1_rst_c0");
    want(3, FPllRst, 1, "t1_rst_c3");      want(4, FPllRst, 0, "t1_rst_c4");
    want(4, FState, 2, "t1_wait");         want(11, FState, 2, "t1_wait_sync");
    want(12, FState, 3, "t1_filter");      want(19, FReady, 0, "t1_not_ready");
    want(20, FReady, 1, "t1_ready");       want(20, FRetry, 0, "t1_retry");
    for (int c = 0; c <= 20; c++) begin
      while (sb.size() > 0 && sb[0].cyc <= c) begin
        e = sb.pop_front(); tests++;
        if (obs(e.field) !== e.val) begin
          failed++; $display("FAIL %s (cycle %0d): got %0d, expected %0d", e.tag, c, obs(e.field), e.val);
        end
      end
      if (c == 9) locked = 1'b1;  // sampled from edge 10 on
      @(negedge clk);
    end
    if (sb.size() != 0) begin tests++; failed++; $display("FAIL t1_leftover: got %0d, expected 0", sb.size()); end
  endtask

  task automatic test_lock_fail_fault();
    exp_t e;
    do_reset(1'b0);
    want(3, FPllRst, 1, "t2_pulse");       want(4, FState, 2, "t2_wait");
    want(103, FState, 2, "t2_pre_to1");    want(104, FState, 1, "t2_to1");
    want(104, FRetry, 1, "t2_retry1");     want(107, FPllRst, 1, "t2_pulse1_end");
    want(108, FState, 2, "t2_wait2");      want(208, FState, 1, "t2_to2");
    want(208, FRetry, 2, "t2_retry2");     want(212, FState, 2, "t2_wait3");
    want(311, FFault, 0, "t2_pre_fault");  want(312, FState, 5, "t2_fault_state");
    want(312, FFault, 1, "t2_fault");      want(312, FRetry, 3, "t2_retry3");
    want(312, FPllRst, 1, "t2_fault_rst"); want(316, FState, 5, "t2_force_ign");
    want(317, FState, 5, "t2_unstable_ign"); want(317, FFault, 1, "t2_sticky");
    want(319, FState, 5, "t2_still_fault"); want(320, FState, 1, "t2_cleared");
    want(320, FRetry, 0, "t2_retry_clr"); want(320, FFault, 0, "t2_fault_clr");
    want(324, FState, 2, "t2_new_wait");
    for (int c = 0; c <= 324; c++) begin
      while (sb.size() > 0 && sb[0].cyc <= c) begin
        e = sb.pop_front(); tests++;
        if (obs(e.field) !== e.val) begin
          failed++; $display("FAIL %s (cycle %0d): got %0d, expected %0d", e.tag, c, obs(e.field), e.val);
        end
      end
      if (c == 315) begin stable = 1'b0; force_r = 1'b1; end
      if (c == 316) force_r = 1'b0;
      if (c == 317) stable = 1'b1;
      if (c == 319) clear_f = 1'b1;
      if (c == 320) clear_f = 1'b0;
      @(negedge clk);
    end
    if (sb.size() != 0) begin tests++; failed++; $display("FAIL t2_leftover: got %0d, expected 0", sb.size()); end
  endtask

  task automatic test_lock_loss();
    exp_t e;
    do_reset(1'b1);
    want(13, FState, 4, "t3_ready");       want(17, FReady, 1, "t3_ready_hold");
    want(17, FLoss, 0, "t3_loss0");        want(18, FState, 1, "t3_relock_pulse");
    want(18, FReady, 0, "t3_ready_fall");  want(18, FLoss, 1, "t3_loss1");
    want(21, FPllRst, 1, "t3_pulse_end");  want(22, FState, 2, "t3_wait");
    want(23, FState, 3, "t3_filter");      want(30, FReady, 0, "t3_not_ready");
    want(31, FReady, 1, "t3_ready_again"); want(31, FLoss, 1, "t3_loss_kept");
    for (int c = 0; c <= 31; c++) begin
      while (sb.size() > 0 && sb[0].cyc <= c) begin
        e = sb.pop_front(); tests++;
        if (obs(e.field) !== e.val) begin
          failed++; $display("FAIL %s (cycle %0d): got %0d, expected %0d", e.tag, c, obs(e.field), e.val);
        end
      end
      if (c == 15) locked = 1'b0;
      if (c == 16) locked = 1'b1;
      @(negedge clk);
    end
    if (sb.size() != 0) begin tests++; failed++; $display("FAIL t3_leftover: got %0d, expected 0", sb.size()); end
  endtask

  // Runs straight after test_lock_loss: READY with lock_loss_count=1
  task automatic test_async_reset();
    #2 rst = 1'b1;
    #1;
    tests += 3;
    if (sup_state !== 3'd1 || pll_reset !== 1'b1) begin
      failed++; $display("FAIL t6_state: got st=%0d rst=%0b, expected 1/1", sup_state, pll_reset);
    end
    if (clocks_ready !== 1'b0 || supervisor_fault !== 1'b0) begin
      failed++; $display("FAIL t6_flags: got rdy=%0b flt=%0b, expected 0/0", clocks_ready, supervisor_fault);
    end
    if (retry_count !== 8'd0 || lock_loss_count !== 16'd0) begin
      failed++; $display("FAIL t6_cnts: got %0d/%0d, expected 0/0", retry_count, lock_loss_count);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_filter_drop();
    exp_t e;
    do_reset(1'b0);
    want(12, FState, 3, "t4_filter");      want(16, FState, 3, "t4_filter5");
    want(17, FState, 3, "t4_drop_seen");   want(18, FState, 2, "t4_back_wait");
    want(21, FState, 2, "t4_wait_sync");   want(22, FState, 3, "t4_refilter");
    want(29, FState, 3, "t4_filter_full"); want(30, FState, 4, "t4_ready");
    for (int c = 0; c <= 30; c++) begin
      while (sb.size() > 0 && sb[0].cyc <= c) begin
        e = sb.pop_front(); tests++;
        if (obs(e.field) !== e.val) begin
          failed++; $display("FAIL %s (cycle %0d): got %0d, expected %0d", e.tag, c, obs(e.field), e.val);
        end
      end
      if (c == 9)  locked = 1'b1;
      if (c == 15) locked = 1'b0;
      if (c == 19) locked = 1'b1;
      @(negedge clk);
    end
    if (sb.size() != 0) begin tests++; failed++; $display("FAIL t4_leftover: got %0d, expected 0", sb.size()); end
  endtask

  // A filter restart late in the window must not restart the timeout
  task automatic test_filter_timer();
    exp_t e;
    do_reset(1'b0);
    want(92, FState, 3, "t4b_filter");     want(98, FState, 2, "t4b_wait");
    want(100, FState, 3, "t4b_refilter");  want(103, FState, 3, "t4b_pre_to");
    want(104, FState, 1, "t4b_timeout");   want(104, FRetry, 1, "t4b_retry");
    for (int c = 0; c <= 104; c++) begin
      while (sb.size() > 0 && sb[0].cyc <= c) begin
        e = sb.pop_front(); tests++;
        if (obs(e.field) !== e.val) begin
          failed++; $display("FAIL %s (cycle %0d): got %0d, expected %0d", e.tag, c, obs(e.field), e.val);
        end
      end
      if (c == 89) locked = 1'b1;
      if (c == 95) locked = 1'b0;
      if (c == 97) locked = 1'b1;
      @(negedge clk);
    end
    if (sb.size() != 0) begin tests++; failed++; $display("FAIL t4b_leftover: got %0d, expected 0", sb.size()); end
  endtask

  task automatic test_hold();
    exp_t e;
    do_reset(1'b0);
    want(9, FState, 2, "t5_wait");         want(9, FPllRst, 0, "t5_rst_low");
    want(10, FState, 0, "t5_hold");        want(10, FPllRst, 1, "t5_hold_rst");
    want(13, FState, 0, "t5_force_ign");   want(14, FPllRst, 1, "t5_hold_rst2");
    want(15, FState, 1, "t5_pulse");       want(18, FPllRst, 1, "t5_pulse_end");
    want(19, FState, 2, "t5_wait2");       want(19, FPllRst, 0, "t5_rst_low2");
    want(19, FRetry, 0, "t5_retry");       want(118, FState, 2, "t5_pre_to");
    want(119, FState, 1, "t5_timeout");    want(119, FRetry, 1, "t5_retry1");
    for (int c = 0; c <= 119; c++) begin
      while (sb.size() > 0 && sb[0].cyc <= c) begin
        e = sb.pop_front(); tests++;
        if (obs(e.field) !== e.val) begin
          failed++; $display("FAIL %s (cycle %0d): got %0d, expected %0d", e.tag, c, obs(e.field), e.val);
        end
      end
      if (c == 9)  stable = 1'b0;
      if (c == 12) force_r = 1'b1;
      if (c == 13) force_r = 1'b0;
      if (c == 14) stable = 1'b1;
      @(negedge clk);
    end
    if (sb.size() != 0) begin tests++; failed++; $display("FAIL t5_leftover: got %0d, expected 0", sb.size()); end
  endtask

  task automatic test_force_relock();
    exp_t e;
    do_reset(1'b1);
    want(15, FState, 4, "t7_ready");       want(16, FState, 1, "t7_forced");
    want(16, FLoss, 0, "t7_no_loss");      want(21, FState, 1, "t7_pulse_restart");
    want(21, FPllRst, 1, "t7_rst");        want(22, FState, 2, "t7_wait");
    want(31, FState, 4, "t7_ready2");      want(31, FLoss, 0, "t7_no_loss2");
    for (int c = 0; c <= 31; c++) begin
      while (sb.size() > 0 && sb[0].cyc <= c) begin
        e = sb.pop_front(); tests++;
        if (obs(e.field) !== e.val) begin
          failed++; $display("FAIL %s (cycle %0d): got %0d, expected %0d", e.tag, c, obs(e.field), e.val);
        end
      end
      if (c == 15 || c == 17) force_r = 1'b1;
      if (c == 16 || c == 18) force_r = 1'b0;
      @(negedge clk);
    end
    if (sb.size() != 0) begin tests++; failed++; $display("FAIL t7_leftover: got %0d, expected 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_lock_fail_fault();
    test_lock_loss();
    test_async_reset();
    test_filter_drop();
    test_filter_timer();
    test_hold();
    test_force_relock();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
